// File: rtl/piso_serializer_pkg.sv
// Shared types and defaults for the PISO serializer and the capture-register bench.
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

    localparam int SER_WIDTH = 4;
    localparam int SER_GAP   = 0;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: valid/ready word input, MSB-first bit stream out,
// with a one-word hold buffer so consecutive words stream without idle bits.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH      = SER_WIDTH,
    parameter int GAP_CYCLES = SER_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             word_start_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;

    logic in_ready_q;
    logic ser_out_q;
    logic ser_valid_q;
    logic word_start_q;
    logic word_done_q;
    logic busy_q;

    logic accept;
    logic last_bit;
    logic last_gap;
    logic load_hold;
    logic load_direct;

    assign accept   = in_valid_i && in_ready_q;
    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    assign last_gap = (state_q == GAP) && (gap_cnt_q == LAST_GAP);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load_hold   = 1'b0;
        load_direct = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load_hold = 1'b1;
                end else begin
                    load_direct = accept;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end else if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else if (hold_full_q) begin
                    load_hold = 1'b1;
                end else if (accept) begin
                    load_direct = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (!last_gap) begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end else if (hold_full_q) begin
                    load_hold = 1'b1;
                end else if (accept) begin
                    load_direct = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_hold) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end
        if (load_direct) begin
            shift_d = in_data_i;
        end
        if (load_hold || load_direct) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
        end

        // A word not loaded straight into the shifter parks in hold; when hold drains
        // on the same edge the new word takes its place, so order is preserved.
        if (accept && !load_direct) begin
            hold_d      = in_data_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            word_start_q <= 1'b0;
            word_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            // Outputs are registered from next-state so they line up with state_q.
            in_ready_q   <= !hold_full_d;
            ser_valid_q  <= (state_d == SHIFT);
            ser_out_q    <= (state_d == SHIFT) && shift_d[WIDTH-1];
            word_start_q <= (state_d == SHIFT) && (bit_cnt_d == '0);
            word_done_q  <= (state_d == SHIFT) && (bit_cnt_d == LAST_BIT);
            busy_q       <= (state_d != IDLE) || hold_full_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign ser_out_o    = ser_out_q;
    assign ser_valid_o  = ser_valid_q;
    assign word_start_o = word_start_q;
    assign word_done_o  = word_done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: three serializer lanes (4-bit/no gap, 4-bit/gap 2, 8-bit/no gap).
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_valid = '0;
    logic [2:0] in_ready;
    logic [2:0] ser_out;
    logic [2:0] ser_valid;
    logic [2:0] word_start;
    logic [2:0] word_done;
    logic [2:0] busy;
    logic [7:0] in_data [3];

    int total = 0;
    int bad   = 0;

    logic [7:0] exp0[$], exp1[$], exp2[$];
    int         gp0[$], gp1[$], gp2[$];
    int         sent [3];
    int         seen [3];
    int         nb   [3];
    int         idle [3];
    logic [7:0] acc  [3];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0][3:0]),
        .ser_out_o(ser_out[0]), .ser_valid_o(ser_valid[0]),
        .word_start_o(word_start[0]), .word_done_o(word_done[0]), .busy_o(busy[0])
    );

    piso_serializer #(.WIDTH(4), .GAP_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1][3:0]),
        .ser_out_o(ser_out[1]), .ser_valid_o(ser_valid[1]),
        .word_start_o(word_start[1]), .word_done_o(word_done[1]), .busy_o(busy[1])
    );

    piso_serializer #(.WIDTH(8), .GAP_CYCLES(0)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .in_data_i(in_data[2]),
        .ser_out_o(ser_out[2]), .ser_valid_o(ser_valid[2]),
        .word_start_o(word_start[2]), .word_done_o(word_done[2]), .busy_o(busy[2])
    );

    task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s lane%0d: got %0h want %0h at %0t", nm, l, act, req, $time);
        end
    endtask

    task automatic push_exp(input int l, input logic [7:0] w, input int g);
        case (l)
            0: begin exp0.push_back(w); gp0.push_back(g); end
            1: begin exp1.push_back(w); gp1.push_back(g); end
            default: begin exp2.push_back(w); gp2.push_back(g); end
        endcase
        sent[l]++;
    endtask

    task automatic pop_gap(input int l, output int g);
        g = -1;
        case (l)
            0: if (gp0.size() > 0) g = gp0.pop_front();
            1: if (gp1.size() > 0) g = gp1.pop_front();
            default: if (gp2.size() > 0) g = gp2.pop_front();
        endcase
    endtask

    task automatic pop_word(input int l, output logic [7:0] w, output bit ok);
        ok = 1'b0;
        w  = '0;
        case (l)
            0: if (exp0.size() > 0) begin w = exp0.pop_front(); ok = 1'b1; end
            1: if (exp1.size() > 0) begin w = exp1.pop_front(); ok = 1'b1; end
            default: if (exp2.size() > 0) begin w = exp2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Per-lane output monitor: reassembles words in a left-shift capture model.
    task automatic mon_lane(input int l);
        int         lw;
        int         g;
        logic [7:0] mask;
        logic [7:0] w;
        bit         ok;
        lw   = (l == 2) ? 8 : 4;
        mask = (l == 2) ? 8'hFF : 8'h0F;
        if (rst) begin
            chk("rst_outputs", l, {ser_out[l], ser_valid[l], word_start[l], word_done[l], busy[l], in_ready[l]}, 0);
            nb[l]   = 0;
            idle[l] = 0;
            acc[l]  = '0;
        end else if (ser_valid[l]) begin
            if (nb[l] == 0) begin
                chk("word_start", l, word_start[l], 1);
                pop_gap(l, g);
                if (g >= 0) chk("idle_gap", l, idle[l], g);
            end else begin
                chk("word_start_mid", l, word_start[l], 0);
            end
            acc[l] = {acc[l][6:0], ser_out[l]};
            nb[l]++;
            chk("word_done", l, word_done[l], (nb[l] == lw));
            chk("busy_while_valid", l, busy[l], 1);
            if (nb[l] == lw) begin
                pop_word(l, w, ok);
                if (!ok) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word lane%0d: got %0h want none", l, acc[l] & mask);
                end else begin
                    chk("word_data", l, acc[l] & mask, w);
                end
                seen[l]++;
                nb[l]   = 0;
                idle[l] = 0;
            end
        end else begin
            chk("idle_outputs", l, {ser_out[l], word_start[l], word_done[l]}, 0);
            chk("word_contiguous", l, nb[l], 0);
            nb[l] = 0;
            idle[l]++;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int l = 0; l < 3; l++) mon_lane(l);
        end
    endtask

    // Presents a word, scrambling in_data while stalled; leaves in_valid low afterwards.
    task automatic send(input int l, input logic [7:0] data, input int g, output int stalls);
        logic [7:0] mask;
        mask   = (l == 2) ? 8'hFF : 8'h0F;
        stalls = 0;
        in_valid[l] = 1'b1;
        in_data[l]  = data;
        while (!in_ready[l] && stalls < 100) begin
            in_data[l] = ~data ^ 8'(stalls);
            @(posedge clk); #1;
            stalls++;
        end
        in_data[l] = data;
        chk("send_ready", l, in_ready[l], 1);
        if (in_ready[l]) push_exp(l, data & mask, g);
        @(posedge clk); #1;
        in_valid[l] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy != 3'b000 || (exp0.size() + exp1.size() + exp2.size()) != 0) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_in_time", 0, (t < 400), 1);
    endtask

    initial begin
        int st;
        for (int l = 0; l < 3; l++) begin
            in_data[l] = '0;
            sent[l] = 0; seen[l] = 0; nb[l] = 0; idle[l] = 0; acc[l] = '0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_rst", 0, in_ready, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 0, in_ready, 3'b111);
        chk("idle_after_rst", 0, {busy, ser_valid}, 0);

        // Single word from IDLE.
        send(0, 8'h0B, -1, st);
        chk("stall_first", 0, st, 0);
        drain();
        chk("capture_reg", 0, acc[0][3:0], 4'hB);

        // Back-to-back stream, in_valid held high.
        send(0, 8'h0A, -1, st);
        send(0, 8'h05, 0, st);
        chk("stall_into_hold", 0, st, 0);
        send(0, 8'h0C, 0, st);
        chk("stall_while_full", 0, st, 3);
        drain();

        // Gap lane: two bit-times of silence between words.
        send(1, 8'h0F, -1, st);
        send(1, 8'h01, 2, st);
        drain();

        // Reset mid-word with a word held.
        send(0, 8'h0C, -1, st);
        send(0, 8'h09, -1, st);
        @(posedge clk); #1;
        rst = 1'b1;
        sent[0] -= exp0.size();
        exp0.delete();
        gp0.delete();
        #1;
        chk("rst_immediate", 0, {ser_out[0], ser_valid[0], word_start[0], word_done[0], busy[0], in_ready[0]}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst2", 0, in_ready[0], 1);
        send(0, 8'h06, -1, st);
        drain();

        // 8-bit lane: random words with random idle spacing.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 10)) begin
                @(posedge clk); #1;
            end
            send(2, 8'($urandom), -1, st);
        end
        drain();

        for (int l = 0; l < 3; l++) chk("word_count", l, seen[l], sent[l]);
        chk("queues_empty", 0, exp0.size() + exp1.size() + exp2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
